// File: rtl/line_window.sv
// Sliding WIDTH_NB x WIDTH_NB neighbourhood generator over a raster stream.
// Runtime row length; ring line buffers feed the older window rows.
module line_window #(
    parameter int WIDTH_NB   = 3,
    parameter int IMG_WIDTH  = 8,
    parameter int MEM_AWIDTH = 8,
    parameter int MEM_DEPTH  = 15
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [MEM_AWIDTH-1:0]                    cfg_delay,
    input  logic                                     cfg_set,
    input  logic [IMG_WIDTH-1:0]                     up_data,
    input  logic                                     up_val,
    output logic [WIDTH_NB*WIDTH_NB*IMG_WIDTH-1:0]   dn_data,
    output logic                                     dn_val
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [MEM_AWIDTH-1:0] DEPTH = MEM_AWIDTH'(MEM_DEPTH);
    localparam logic [MEM_AWIDTH-1:0] ONE   = MEM_AWIDTH'(1);

    typedef logic [WIDTH_NB-1:0][WIDTH_NB-1:0][IMG_WIDTH-1:0] win_t;

    logic [IMG_WIDTH-1:0]  lb    [WIDTH_NB-1][MEM_DEPTH];
    logic [IMG_WIDTH-1:0]  lb_rd [WIDTH_NB-1];
    logic [MEM_AWIDTH-1:0] len_q, len_d;
    logic [MEM_AWIDTH-1:0] col_q, col_d, col_cur;
    logic [AW-1:0]         addr;
    win_t                  win_q, win_d;
    logic                  val_q;

    // A concurrent cfg_set makes this pixel the first one under the new length.
    always_comb begin
        len_d = len_q;
        if (cfg_set) begin
            if (cfg_delay <= ONE)
                len_d = ONE;
            else if (cfg_delay > DEPTH)
                len_d = DEPTH;
            else
                len_d = cfg_delay;
        end
        col_cur = cfg_set ? '0 : col_q;
        col_d   = col_cur;
        if (up_val)
            col_d = (col_cur == len_d - ONE) ? '0 : col_cur + ONE;
    end

    assign addr = col_cur[AW-1:0];

    always_comb begin
        for (int k = 0; k < WIDTH_NB - 1; k++)
            lb_rd[k] = lb[k][addr];
    end

    always_comb begin
        win_d = cfg_set ? '0 : win_q;
        if (up_val) begin
            for (int r = 0; r < WIDTH_NB; r++)
                for (int c = WIDTH_NB - 1; c > 0; c--)
                    win_d[r][c] = win_d[r][c-1];
            win_d[0][0] = up_data;
            for (int r = 1; r < WIDTH_NB; r++)
                win_d[r][0] = cfg_set ? '0 : lb_rd[r-1];
        end
    end

    // Each buffer cascades its old entry into the next one at the same column.
    always_ff @(posedge clk) begin
        if (!rst && up_val) begin
            lb[0][addr] <= up_data;
            for (int k = 1; k < WIDTH_NB - 1; k++)
                lb[k][addr] <= lb_rd[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q <= DEPTH;
            col_q <= '0;
            win_q <= '0;
            val_q <= 1'b0;
        end else begin
            len_q <= len_d;
            col_q <= col_d;
            win_q <= win_d;
            val_q <= up_val;
        end
    end

    assign dn_data = win_q;
    assign dn_val  = val_q;

endmodule

// File: tb/tb_line_window.sv
// Bench for line_window: history-based window model checked every cycle,
// plus hand-computed window literals for the directed scenarios.
module tb_line_window;

    localparam int N = 3;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       cfg_delay;
    logic             cfg_set;
    logic [W-1:0]     up_data;
    logic             up_val;
    logic [N*N*W-1:0] dn_data;
    logic             dn_val;

    always #5 clk = ~clk;

    line_window #(
        .WIDTH_NB  (N),
        .IMG_WIDTH (W),
        .MEM_AWIDTH(8),
        .MEM_DEPTH (15)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_delay(cfg_delay),
        .cfg_set  (cfg_set),
        .up_data  (up_data),
        .up_val   (up_val),
        .dn_data  (dn_data),
        .dn_val   (dn_val)
    );

    int tests = 0;
    int fails = 0;

    // Model: pixels accepted since the last reset/config, plus current length.
    int L = 15;
    int hist[$];
    bit conc = 1'b0;
    bit exp_val = 1'b0;
    bit armed = 1'b0;

    function automatic int fld(int r, int c);
        return int'(dn_data[(r*N+c)*W +: W]);
    endfunction

    task automatic tick(input bit r, input bit c, input int d,
                        input bit v, input int px);
        rst       = r;
        cfg_set   = c;
        cfg_delay = 8'(d);
        up_val    = v;
        up_data   = 8'(px);
        @(posedge clk);
        if (r) begin
            L = 15;
            hist.delete();
            conc = 1'b0;
        end else begin
            if (c) begin
                L = (d <= 1) ? 1 : (d > 15) ? 15 : d;
                hist.delete();
                conc = v;
            end
            if (v) hist.push_back(px);
        end
        exp_val = v && !r;
        armed = 1'b1;
        #1;
    endtask

    task automatic stream(input int first, input int last);
        for (int p = first; p <= last; p++)
            tick(1'b0, 1'b0, 0, 1'b1, p);
    endtask

    task automatic lit(input string nm, input int got, input int want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic lit_win(input string nm, input int e[9]);
        for (int i = 0; i < 9; i++)
            lit($sformatf("%s(%0d,%0d)", nm, i / 3, i % 3),
                fld(i / 3, i % 3), e[i]);
    endtask

    // Field (r,c) holds segment pixel n-c-r*L; cleared if that entry
    // predates the segment; unknown if it came from stale line memory.
    always @(negedge clk) begin
        int  n, j, e;
        bit  known;
        if (armed) begin
            tests++;
            if (dn_val !== exp_val) begin
                fails++;
                $display("FAIL dn_val t=%0t: got %b want %b",
                         $time, dn_val, exp_val);
            end
            n = hist.size() - 1;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    j = n - c;
                    known = 1'b1;
                    e = 0;
                    if (j < 0)
                        e = 0;
                    else if (j == 0 && conc && r > 0)
                        e = 0;
                    else if (j - r * L >= 0)
                        e = hist[j - r*L];
                    else
                        known = 1'b0;
                    if (known) begin
                        tests++;
                        if (fld(r, c) !== e) begin
                            fails++;
                            $display("FAIL win(%0d,%0d) t=%0t: got %0d want %0d",
                                     r, c, $time, fld(r, c), e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; cfg_set = 1'b0; cfg_delay = '0;
        up_val = 1'b1; up_data = '0;

        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0, 0, 1'b1, 200 + i);
            lit("rst_val", int'(dn_val), 0);
            lit("rst_data_nz", int'(dn_data != '0), 0);
        end
        stream(1, 31);
        lit("reset_len15", fld(2, 0), 1);

        tick(1'b0, 1'b1, 4, 1'b0, 0);
        stream(1, 11);
        lit_win("basic11", '{11, 10, 9, 7, 6, 5, 3, 2, 1});
        stream(12, 16);
        lit_win("basic16", '{16, 15, 14, 12, 11, 10, 8, 7, 6});
        tick(1'b0, 1'b0, 0, 1'b0, 0);
        lit("after_val", int'(dn_val), 0);

        tick(1'b0, 1'b1, 4, 1'b0, 0);
        stream(1, 8);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 0, 1'b0, 0);
            lit("gap_val", int'(dn_val), 0);
            lit("gap_f00", fld(0, 0), 8);
            lit("gap_f12", fld(1, 2), 2);
        end
        stream(9, 16);
        lit_win("gap16", '{16, 15, 14, 12, 11, 10, 8, 7, 6});

        tick(1'b0, 1'b1, 0, 1'b0, 0);
        stream(1, 5);
        lit_win("clamp0", '{5, 4, 3, 4, 3, 2, 3, 2, 1});
        tick(1'b0, 1'b1, 20, 1'b0, 0);
        stream(1, 16);
        lit("clamp20_f10", fld(1, 0), 1);

        tick(1'b0, 1'b1, 4, 1'b1, 50);
        lit("conc_val", int'(dn_val), 1);
        lit_win("conc", '{50, 0, 0, 0, 0, 0, 0, 0, 0});
        stream(51, 58);
        lit("conc_f10", fld(1, 0), 54);
        lit("conc_f20", fld(2, 0), 50);

        tick(1'b0, 1'b1, 4, 1'b0, 0);
        stream(1, 9);
        tick(1'b1, 1'b0, 0, 1'b1, 10);
        lit("mid_val", int'(dn_val), 0);
        lit("mid_data_nz", int'(dn_data != '0), 0);
        stream(101, 116);
        lit("mid_len15", fld(1, 0), 101);
        tick(1'b0, 1'b1, 4, 1'b0, 0);
        stream(1, 11);
        lit_win("mid11", '{11, 10, 9, 7, 6, 5, 3, 2, 1});

        tick(1'b0, 1'b0, 0, 1'b0, 0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
